// File: rtl/isp_mode_ctrl.sv
// -----------------------------------------------------------------------------
// isp_mode_ctrl
//
// Owns the display-mode select (RAW/CFA/AWB/CCM/GMA) that picks which ISP stage
// is shown. Mode changes come from a host valid/ready request, a "next" key
// pulse or an auto-cycle timer, and are only ever applied on a frame start
// (rising edge of in_vsync), so the picture never switches mid-frame.
// Also checks raw frame geometry and counts frames for debug.
//
// Ports:
//   clk            pixel clock
//   reset          synchronous reset, active-high
//   in_vsync       raw frame sync; rising edge = frame start
//   in_hsync       raw line sync (not used by the logic)
//   in_den         raw data enable
//   req_valid      host mode request valid
//   req_mode[3:0]  requested mode
//   req_ready      controller can accept a host request (IDLE, not in reset)
//   key_next       one-cycle pulse: advance to the next mode
//   auto_en        enable auto-cycling every AUTO_FRAMES frames
//   isp_disp_mode  active display mode for the ISP top
//   mode_switched  one-cycle pulse after isp_disp_mode is updated
//   req_err        one-cycle pulse after an illegal req_mode is rejected
//   frame_cnt      vsync rising edges since reset (wraps)
//   frame_err      geometry mismatch of the last completed frame
// -----------------------------------------------------------------------------
module isp_mode_ctrl #(
  parameter int source_h    = 1024,
  parameter int source_v    = 1024,
  parameter int NUM_MODES   = 5,
  parameter int AUTO_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_vsync,
  input  logic        in_hsync,
  input  logic        in_den,
  input  logic        req_valid,
  input  logic [3:0]  req_mode,
  output logic        req_ready,
  input  logic        key_next,
  input  logic        auto_en,
  output logic [3:0]  isp_disp_mode,
  output logic        mode_switched,
  output logic        req_err,
  output logic [15:0] frame_cnt,
  output logic        frame_err
);

  localparam int PIX_W  = ($clog2(source_h + 1) > 16) ? $clog2(source_h + 1) : 16;
  localparam int LINE_W = ($clog2(source_v + 1) > 16) ? $clog2(source_v + 1) : 16;
  localparam int AUTO_W = $clog2(AUTO_FRAMES + 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } state_t;

  state_t              r_state, w_state_next;
  logic [3:0]          r_mode, w_mode_next;
  logic [3:0]          r_pend_mode, w_pend_next;
  logic                r_switched, w_apply;
  logic                r_req_err, w_req_err_next;
  logic                r_vs_d, r_den_d;
  logic [AUTO_W-1:0]   r_auto_cnt;
  logic [15:0]         r_frame_cnt;
  logic [PIX_W-1:0]    r_pix_cnt;
  logic [LINE_W-1:0]   r_line_cnt;
  logic                r_line_bad;
  logic                r_first_frame;
  logic                r_frame_err;

  logic                w_vs_rise, w_den_fall;
  logic                w_req_legal, w_auto_term;
  logic [3:0]          w_mode_inc;
  logic                w_line_done_bad;
  logic [LINE_W-1:0]   w_line_inc, w_lines_final;
  logic                w_frame_bad;
  logic                w_unused_hsync;

  assign w_unused_hsync = in_hsync;

  assign w_vs_rise   = in_vsync & ~r_vs_d;
  assign w_den_fall  = ~in_den & r_den_d;
  assign w_req_legal = ({1'b0, req_mode} < 5'(NUM_MODES));
  assign w_auto_term = (r_auto_cnt == AUTO_W'(AUTO_FRAMES - 1));
  assign w_mode_inc  = (r_mode >= 4'(NUM_MODES - 1)) ? 4'd0 : r_mode + 4'd1;

  // A line ending on the same cycle as the frame start still belongs to the
  // frame being closed, so fold it into the verdict here.
  assign w_line_done_bad = w_den_fall && (r_pix_cnt != PIX_W'(source_h));
  assign w_line_inc      = (r_line_cnt == '1) ? r_line_cnt : r_line_cnt + LINE_W'(1);
  assign w_lines_final   = w_den_fall ? w_line_inc : r_line_cnt;
  // in_den still high across the frame start means a truncated line.
  assign w_frame_bad     = (w_lines_final != LINE_W'(source_v)) | r_line_bad |
                           w_line_done_bad | (in_den & r_den_d);

  // Next-state / command arbitration: host > key > auto.
  always_comb begin
    w_state_next   = r_state;
    w_mode_next    = r_mode;
    w_pend_next    = r_pend_mode;
    w_apply        = 1'b0;
    w_req_err_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_legal) begin
            w_pend_next  = req_mode;
            w_state_next = S_PENDING;
          end else begin
            w_req_err_next = 1'b1;
          end
        end else if (key_next) begin
          w_pend_next  = w_mode_inc;
          w_state_next = S_PENDING;
        end else if (auto_en && w_vs_rise && w_auto_term) begin
          // Auto-cycle already sits on a frame boundary: apply immediately.
          w_mode_next = w_mode_inc;
          w_apply     = 1'b1;
        end
      end
      S_PENDING: begin
        if (w_vs_rise) begin
          w_mode_next  = r_pend_mode;
          w_apply      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mode        <= 4'd0;
      r_pend_mode   <= 4'd0;
      r_switched    <= 1'b0;
      r_req_err     <= 1'b0;
      r_vs_d        <= 1'b0;
      r_den_d       <= 1'b0;
      r_auto_cnt    <= '0;
      r_frame_cnt   <= 16'd0;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_line_bad    <= 1'b0;
      r_first_frame <= 1'b1;
      r_frame_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mode      <= w_mode_next;
      r_pend_mode <= w_pend_next;
      r_switched  <= w_apply;
      r_req_err   <= w_req_err_next;
      r_vs_d      <= in_vsync;
      r_den_d     <= in_den;

      // Holds at the terminal value if a host/key command wins that frame;
      // the pending switch then clears it.
      if (!auto_en || w_apply) begin
        r_auto_cnt <= '0;
      end else if (w_vs_rise && !w_auto_term) begin
        r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
      end

      if (w_vs_rise) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      if (w_vs_rise) begin
        // The partial frame seen before the first vsync is never judged.
        if (!r_first_frame) begin
          r_frame_err <= w_frame_bad;
        end
        r_first_frame <= 1'b0;
        r_line_cnt    <= '0;
        r_line_bad    <= 1'b0;
        r_pix_cnt     <= '0;
      end else if (w_den_fall) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= w_line_inc;
        if (w_line_done_bad) begin
          r_line_bad <= 1'b1;
        end
      end else if (in_den && (r_pix_cnt != '1)) begin
        r_pix_cnt <= r_pix_cnt + PIX_W'(1);
      end
    end
  end

  assign req_ready     = (r_state == S_IDLE) && !reset;
  assign isp_disp_mode = r_mode;
  assign mode_switched = r_switched;
  assign req_err       = r_req_err;
  assign frame_cnt     = r_frame_cnt;
  assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_isp_mode_ctrl.sv
module tb_isp_mode_ctrl;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int NM = 5;
  localparam int AF = 3;

  logic        clk = 1'b0;
  logic        reset, in_vsync, in_hsync, in_den, req_valid, key_next, auto_en;
  logic [3:0]  req_mode;
  logic        req_ready, mode_switched, req_err, frame_err;
  logic [3:0]  isp_disp_mode;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  isp_mode_ctrl #(
    .source_h(H), .source_v(V), .NUM_MODES(NM), .AUTO_FRAMES(AF)
  ) dut (
    .clk(clk), .reset(reset), .in_vsync(in_vsync), .in_hsync(in_hsync),
    .in_den(in_den), .req_valid(req_valid), .req_mode(req_mode),
    .req_ready(req_ready), .key_next(key_next), .auto_en(auto_en),
    .isp_disp_mode(isp_disp_mode), .mode_switched(mode_switched),
    .req_err(req_err), .frame_cnt(frame_cnt), .frame_err(frame_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: mode and pending request as plain integers, frame
  // geometry kept as a list of observed line lengths judged at frame start.
  int m_mode, m_pend, m_auto, m_frames, m_cur;
  bit m_vs_prev, m_den_prev, m_seen, m_ferr, m_sw, m_err;
  int m_lines[$];
  bit g_open = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit vr, df, bad;
    if (reset) begin
      m_mode = 0; m_pend = -1; m_auto = 0; m_frames = 0; m_cur = 0;
      m_vs_prev = 0; m_den_prev = 0; m_seen = 0; m_ferr = 0; m_sw = 0; m_err = 0;
      m_lines.delete();
      return;
    end
    vr = in_vsync && !m_vs_prev;
    df = !in_den && m_den_prev;
    m_sw = 0;
    m_err = 0;
    if (m_pend < 0) begin
      if (req_valid) begin
        if (int'(req_mode) < NM) m_pend = int'(req_mode);
        else m_err = 1;
      end else if (key_next) begin
        m_pend = (m_mode + 1) % NM;
      end else if (auto_en && vr && m_auto == AF - 1) begin
        m_mode = (m_mode + 1) % NM;
        m_sw = 1;
      end
    end else if (vr) begin
      m_mode = m_pend;
      m_pend = -1;
      m_sw = 1;
    end
    if (!auto_en || m_sw) m_auto = 0;
    else if (vr && m_auto < AF - 1) m_auto++;
    if (vr) m_frames = (m_frames + 1) % 65536;
    if (in_den) m_cur++;
    if (df) begin
      m_lines.push_back(m_cur);
      m_cur = 0;
    end
    if (vr) begin
      bad = (m_lines.size() != V) || (in_den && m_den_prev);
      foreach (m_lines[i]) if (m_lines[i] != H) bad = 1;
      if (m_seen) m_ferr = bad;
      m_seen = 1;
      m_lines.delete();
      m_cur = 0;
    end
    m_vs_prev = in_vsync;
    m_den_prev = in_den;
  endtask

  // One clock: drive inputs, advance model, sample outputs 1 ns after the edge.
  task automatic step(input bit rst, input bit vs, input bit den, input bit rv,
                      input int rm, input bit kn, input bit ae);
    reset = rst; in_vsync = vs; in_den = den; in_hsync = den;
    req_valid = rv; req_mode = rm[3:0]; key_next = kn; auto_en = ae;
    model_step();
    @(posedge clk);
    #1;
    check("mode", int'(isp_disp_mode), m_mode);
    check("switched", int'(mode_switched), int'(m_sw));
    check("req_err", int'(req_err), int'(m_err));
    check("ready", int'(req_ready), int'(!rst && m_pend < 0));
    check("frame_cnt", int'(frame_cnt), m_frames);
    check("frame_err", int'(frame_err), int'(m_ferr));
  endtask

  task automatic cyc(input bit vs, input bit den, input bit rnd, input bit ae);
    bit rv, kn;
    int rm;
    rv = rnd && ($urandom_range(0, 15) == 0);
    kn = rnd && ($urandom_range(0, 15) == 0);
    rm = $urandom_range(0, 7);
    step(1'b0, vs, den, rv, rm, kn, ae);
  endtask

  // Frame: 2 vsync cycles, 2 blank, then lines of den pulses with 2-cycle gaps.
  task automatic send_frame(input int nlines, input int short_idx, input bit rnd,
                            input bit ae, input bit tail_open, output bit fe_start);
    int len, r;
    cyc(1'b1, g_open, rnd, ae);
    fe_start = frame_err;
    g_open = 1'b0;
    cyc(1'b1, 1'b0, rnd, ae);
    cyc(1'b0, 1'b0, rnd, ae);
    cyc(1'b0, 1'b0, rnd, ae);
    for (int l = 0; l < nlines; l++) begin
      if (rnd) begin
        r = $urandom_range(0, 9);
        len = (r == 0) ? H - 1 : (r == 1) ? H + 1 : H;
      end else begin
        len = (l == short_idx) ? H - 1 : H;
      end
      for (int p = 0; p < len; p++) cyc(1'b0, 1'b1, rnd, ae);
      if (tail_open && l == nlines - 1) begin
        g_open = 1'b1;
      end else begin
        cyc(1'b0, 1'b0, rnd, ae);
        cyc(1'b0, 1'b0, rnd, ae);
      end
    end
  endtask

  typedef struct {
    bit rst, vs, rv;
    int rm;
    bit kn, ae;
    int mode;
    bit sw, err, rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit vs, bit rv, int rm, bit kn, bit ae,
                              int mode, bit sw, bit err, bit rdy);
    vec_t v;
    v.rst = rst; v.vs = vs; v.rv = rv; v.rm = rm; v.kn = kn; v.ae = ae;
    v.mode = mode; v.sw = sw; v.err = err; v.rdy = rdy;
    tbl.push_back(v);
  endfunction

  initial begin
    bit fe;
    int nl;
    //   rst vs rv rm kn ae | mode sw err rdy
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // reset
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    add(0, 0, 1, 3, 0, 0,   0, 0, 0, 0);  // host req 3 mid-frame
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   3, 1, 0, 1);  // applied on vsync rise
    add(0, 1, 0, 0, 0, 0,   3, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   3, 0, 0, 1);
    add(0, 0, 1, 7, 0, 0,   3, 0, 1, 1);  // illegal request
    add(0, 0, 0, 0, 0, 0,   3, 0, 0, 1);
    add(0, 0, 1, 4, 0, 0,   3, 0, 0, 0);  // go to mode 4
    add(0, 1, 0, 0, 0, 0,   4, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0,   4, 0, 0, 0);  // key: 4 -> 0 wrap
    add(0, 0, 0, 0, 1, 0,   4, 0, 0, 0);  // key while pending ignored
    add(0, 0, 1, 2, 0, 0,   4, 0, 0, 0);  // host while pending ignored
    add(0, 1, 0, 0, 0, 0,   0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    add(0, 1, 1, 1, 0, 0,   0, 0, 0, 0);  // accept on vsync-rise edge
    add(0, 1, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   1, 1, 0, 1);  // applied on the following rise
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 1);  // auto from mode 1
    add(0, 1, 0, 0, 0, 1,   1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1,   1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1,   2, 1, 0, 1);  // third rise -> 2
    add(0, 0, 0, 0, 0, 1,   2, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1,   2, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1,   2, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1,   2, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1,   2, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1,   3, 1, 0, 1);  // -> 3
    add(0, 0, 0, 0, 0, 1,   3, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1,   3, 0, 0, 1);  // auto count 1
    add(0, 0, 1, 0, 0, 1,   3, 0, 0, 0);  // host req 0 mid-count
    add(0, 1, 0, 0, 0, 1,   0, 1, 0, 1);  // host applied, auto restarts
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1,   0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1,   0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1,   1, 1, 0, 1);  // three rises after restart
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1,   1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1,   1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 1);
    add(0, 1, 1, 2, 1, 1,   1, 0, 0, 0);  // host + key + auto terminal: host wins
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1,   2, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,   2, 0, 0, 1);
    add(0, 0, 1, 4, 0, 0,   2, 0, 0, 0);  // pending, then reset
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 0, 0, 1);  // pending dropped
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].vs, 1'b0, tbl[i].rv, tbl[i].rm, tbl[i].kn, tbl[i].ae);
      check($sformatf("tv%0d_mode", i), int'(isp_disp_mode), tbl[i].mode);
      check($sformatf("tv%0d_sw", i), int'(mode_switched), int'(tbl[i].sw));
      check($sformatf("tv%0d_err", i), int'(req_err), int'(tbl[i].err));
      check($sformatf("tv%0d_rdy", i), int'(req_ready), int'(tbl[i].rdy));
      $display("vec %0d: mode=%0d sw=%0d err=%0d rdy=%0d", i, isp_disp_mode,
               mode_switched, req_err, req_ready);
    end

    // Geometry: junk before first vsync, then a sequence of good/bad frames.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("geo_reset_fcnt", int'(frame_cnt), 0);
    check("geo_reset_ferr", int'(frame_err), 0);
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 5; p++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    send_frame(V, -1, 1'b0, 1'b0, 1'b0, fe);
    check("geo_first_frame", int'(fe), 0);
    $display("geo frame 0 (good): frame_err at start=%0d", fe);
    send_frame(V, 2, 1'b0, 1'b0, 1'b0, fe);
    check("geo_after_good", int'(fe), 0);
    $display("geo frame 1 (short line): frame_err at start=%0d", fe);
    send_frame(V + 1, -1, 1'b0, 1'b0, 1'b0, fe);
    check("geo_after_short", int'(fe), 1);
    check("geo_hold", int'(frame_err), 1);
    $display("geo frame 2 (5 lines): frame_err at start=%0d", fe);
    send_frame(V, -1, 1'b0, 1'b0, 1'b0, fe);
    check("geo_after_5lines", int'(fe), 1);
    $display("geo frame 3 (good): frame_err at start=%0d", fe);
    send_frame(V, -1, 1'b0, 1'b0, 1'b0, fe);
    check("geo_after_good2", int'(fe), 0);
    check("geo_frame_cnt", int'(frame_cnt), 5);
    $display("geo frame 4 (good): frame_err at start=%0d frame_cnt=%0d", fe, frame_cnt);

    // Randomized frames and commands against the model.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int f = 0; f < 40; f++) begin
      if (f == 20) begin
        step(1, 0, 0, 0, 0, 0, 0);
        g_open = 1'b0;
      end
      nl = $urandom_range(0, 5);
      nl = (nl == 0) ? V - 1 : (nl == 1) ? V + 1 : V;
      send_frame(nl, -1, 1'b1, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 7) == 0), fe);
      $display("rand frame %0d: lines=%0d mode=%0d frame_cnt=%0d frame_err=%0d",
               f, nl, isp_disp_mode, frame_cnt, frame_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/isp_mode_ctrl.md
Name: isp_mode_ctrl

Overview:
- Owns the `isp_disp_mode` select that chooses which ISP stage is shown: RAW, CFA, AWB, CCM or GMA.
- Accepts mode-change commands from three sources and applies each one only at a frame boundary, so the display never switches mid-frame. The sources are a host valid/ready request, a "next" key pulse and an auto-cycle timer.
- Also monitors input frame geometry against `source_h`/`source_v` and keeps a frame counter for debug.
- Sits between the control/UI logic and the ISP top; observes the raw sensor timing.

Parameters:
- `source_h`, 1024, expected `in_den`-high pixels per line.
- `source_v`, 1024, expected lines (`in_den` bursts) per frame.
- `NUM_MODES`, 5, number of legal modes; legal range is 0..NUM_MODES-1.
- `AUTO_FRAMES`, 60, frames per mode in auto-cycle; legal values ≥1.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  synchronous reset, active-high.
- `in_vsync`  in  1  raw frame sync, active-high; its rising edge marks frame start.
- `in_hsync`  in  1  raw line sync; unused except pass-through timing.
- `in_den`  in  1  raw data enable.
- `req_valid`  in  1  host mode request valid.
- `req_mode`  in  4  requested mode.
- `req_ready`  out  1  controller can accept a request.
- `key_next`  in  1  single-cycle pulse: advance to the next mode.
- `auto_en`  in  1  enable auto-cycle.
- `isp_disp_mode`  out  4  active display mode, fed to the ISP top.
- `mode_switched`  out  1  1-cycle pulse when `isp_disp_mode` is updated.
- `req_err`  out  1  1-cycle pulse when an illegal `req_mode` is rejected.
- `frame_cnt`  out  16  count of vsync rising edges since reset.
- `frame_err`  out  1  geometry mismatch flag for the last completed frame.

Behaviour:
- Reset values (`reset`=1, synchronous): `isp_disp_mode`=0, state=IDLE, `req_ready`=0 during reset, `mode_switched`=0, `req_err`=0, `frame_cnt`=0, `frame_err`=0. All internal counters are 0 and `first_frame`=1. Reset asserted in PENDING drops the pending mode.
- vs_rise = `in_vsync` & ~vs_d, where vs_d is `in_vsync` registered. The same for den_fall using den_d.
- State machine, two states:
  - IDLE: `req_ready`=1.
    - If `req_valid` & `req_mode`<NUM_MODES, latch pend_mode=`req_mode` and go to PENDING.
    - If `req_valid` & `req_mode`≥NUM_MODES, pulse `req_err` the next cycle and stay IDLE. This is a consumed handshake.
    - Else if `key_next`, pend_mode=(`isp_disp_mode`+1) mod NUM_MODES and go to PENDING.
    - Else if `auto_en` & vs_rise & auto_cnt==AUTO_FRAMES-1, apply (`isp_disp_mode`+1) mod NUM_MODES on this same edge, pulse `mode_switched`, and stay IDLE.
    - Priority: host request > key > auto.
  - PENDING: `req_ready`=0; `req_valid` and `key_next` are ignored and not queued.
    - On vs_rise: `isp_disp_mode`<=pend_mode on that edge, `mode_switched`=1 for exactly the following cycle, go to IDLE.
    - Applying a mode equal to the current one still pulses `mode_switched`.
- Latency: a request accepted at edge k is applied at the first edge j>k that samples vs_rise. If vs_rise occurs on the accept edge itself, it is not used.
- auto_cnt:
  - Increments on vs_rise while `auto_en`=1, from 0 to AUTO_FRAMES-1.
  - Clears to 0 on any applied switch, and when `auto_en`=0.
- `frame_cnt`: +1 on each vs_rise; wraps 16'hFFFF→0.
- Geometry monitor:
  - pix_cnt: increments while `in_den`=1.
  - On den_fall: compare pix_cnt with `source_h`, set line_bad if they differ, increment line_cnt, clear pix_cnt.
  - On vs_rise: `frame_err`<=(line_cnt≠`source_v`)|line_bad, but only when `first_frame`=0. Then clear line_cnt, line_bad, pix_cnt and set `first_frame`=0.
  - `frame_err` holds until the next vs_rise.
  - pix_cnt and line_cnt saturate at all-ones. Use 16-bit counters minimum, sized by clog2 of the parameter+1.
- `in_den` still high when vsync rises: the partial line is discarded and counts toward line_bad.

Test Plan (bench parameters: `source_h`=8, `source_v`=4, AUTO_FRAMES=3, frame = 4 lines × 8 den cycles):
1. Reset → all outputs 0. Send `req_mode`=3 mid-frame → `req_ready` drops next cycle. `isp_disp_mode` stays 0 until the edge sampling the next vsync rise, then becomes 3; `mode_switched` high exactly 1 cycle.
2. `req_mode`=7 in IDLE → `req_err` 1-cycle pulse; state stays IDLE; `isp_disp_mode` unchanged.
3. Mode 4 + `key_next` → mode 0 after the next vsync rise (wrap). `key_next` pulses while PENDING → ignored, no double advance.
4. `auto_en`=1 from mode 1 → mode 2 after 3 vsync rises, then mode 3 after 3 more. A host request mid-count → the host mode is applied and auto_cnt restarts.
5. Same cycle: `req_valid`(mode 2), `key_next` and auto terminal count all in IDLE → the host wins; mode becomes 2 only at the next vsync.
6. Geometry:
   - First frame → `frame_err`=0.
   - Frame with one 7-pixel line → `frame_err`=1 at the next vsync rise.
   - Frame with 5 lines → `frame_err`=1.
   - Correct frame → `frame_err`=0.
   - `frame_cnt` preloaded to FFFF → 0.
   - Reset asserted while PENDING → mode 0, no `mode_switched`.
